comm_mem_slave: RTL and testbench

- On-chip scratchpad slave that services the memory-request handshake issued by the UART comm controller (req/rw/add/block out; ready/done/valid/data back).
- Sits directly downstream of the UART system on the comm clock domain.
- Gives the host-side loader a word-addressed RAM target for single and block read/write transfers.

---
 rtl/comm_mem_slave_pkg.sv | 29 ++
 rtl/comm_mem_slave_if.sv | 31 +++
 rtl/comm_mem_slave_scratch_ram.sv | 31 +++
 rtl/comm_mem_slave.sv | 154 +++++++++++++++
 tb/tb_comm_mem_slave.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/comm_mem_slave_pkg.sv
// Shared types and constants for the comm scratchpad slave.
// Holds the FSM state encoding, the read/write encoding and a ceiling-log2 helper.
package comm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic RW_READ    = 1'b0;
    localparam logic RW_WRITE   = 1'b1;
    localparam int   WORD_BYTES = 4;

    // Smallest r with 2**r >= value; used to size counters and RAM addresses.
    function automatic int log2_ceil(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comm_mem_slave_if.sv
// Memory-request handshake between the UART comm controller (master) and the scratchpad (slave).
// A request is accepted on any rising edge where req_i and ready_o are both high; ready_o stays low
// until the transaction ends, and done_o pulses for one cycle at its end (never after a clear or reset).
interface comm_mem_slave_if #(
    parameter int ADDR_W = 27
);
    logic [2:0]        reqdev_i;
    logic              req_i;
    logic              req_block_i;
    logic              rw_i;
    logic [ADDR_W-1:0] add_i;
    logic [31:0]       data_i;
    logic              data_valid_i;
    logic              clear_i;
    logic              ready_o;
    logic              done_o;
    logic              valid_o;
    logic [31:0]       data_o;
    logic [2:0]        reqdev_o;
    logic              error_o;

    modport master (
        output reqdev_i, req_i, req_block_i, rw_i, add_i, data_i, data_valid_i, clear_i,
        input  ready_o, done_o, valid_o, data_o, reqdev_o, error_o
    );

    modport slave (
        input  reqdev_i, req_i, req_block_i, rw_i, add_i, data_i, data_valid_i, clear_i,
        output ready_o, done_o, valid_o, data_o, reqdev_o, error_o
    );
endinterface

// File: rtl/comm_mem_slave_scratch_ram.sv
// Single-port synchronous scratchpad RAM, 32-bit words, registered read.
// Read-during-write returns the old word; reset clears only the read register, never the array.
module scratch_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // rdata only moves on a read, so it holds the last word read in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/comm_mem_slave.sv
// Scratchpad slave for the UART comm controller: single-word and aligned block read/write
// transfers into a word-addressed RAM, with an out-of-range check made at request accept.
module comm_mem_slave
    import comm_mem_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 27
) (
    input  logic              clock_i,
    input  logic              reset_i,
    comm_mem_slave_if.slave   bus,
    output state_t            state_dbg
);
    localparam int AW      = log2_ceil(MEM_WORDS);
    localparam int BLK_LSB = log2_ceil(BLOCK_WORDS);
    localparam int CNT_W   = BLK_LSB + 1;
    localparam int BW      = ADDR_W - 2;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic [AW-1:0]    base;
    logic             err_flag;
    logic             ready_r;
    logic             done_r;
    logic             valid_r;
    logic             error_r;
    logic [2:0]       reqdev_r;

    logic [BW-1:0]    req_base;
    logic [CNT_W-1:0] req_len;
    logic [BW:0]      req_end;
    logic             req_oor;

    logic             ram_we;
    logic             ram_re;
    logic [AW-1:0]    ram_addr;
    logic [31:0]      ram_rdata;

    // Range check uses one extra bit so base+N never wraps before the compare.
    always_comb begin
        req_base = bus.add_i[ADDR_W-1:2];
        req_len  = CNT_W'(1);
        if (bus.req_block_i) begin
            req_base[BLK_LSB-1:0] = '0;
            req_len               = CNT_W'(BLOCK_WORDS);
        end
        req_end = {1'b0, req_base} + (BW+1)'(req_len);
        req_oor = req_end > (BW+1)'(MEM_WORDS);
    end

    // READ/WRITE are only entered for in-range requests, so base+cnt fits in AW bits.
    always_comb begin
        ram_addr = base + AW'(cnt);
        ram_re   = (state == READ) && !bus.clear_i && !reset_i;
        ram_we   = (state == WRITE) && bus.data_valid_i && !bus.clear_i && !reset_i;
    end

    scratch_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clock_i),
        .rst   (reset_i),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus.data_i),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state    <= IDLE;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
            error_r  <= 1'b0;
            reqdev_r <= '0;
            cnt      <= '0;
            len      <= '0;
            base     <= '0;
            err_flag <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_i && ready_r && !bus.clear_i) begin
                        reqdev_r <= bus.reqdev_i;
                        base     <= req_base[AW-1:0];
                        len      <= req_len;
                        cnt      <= '0;
                        err_flag <= req_oor;
                        ready_r  <= 1'b0;
                        if (req_oor) begin
                            state <= DONE;
                        end else if (bus.rw_i == RW_WRITE) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (bus.clear_i) begin
                        state   <= IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        // valid follows the issued address by the RAM's one-cycle latency.
                        valid_r <= 1'b1;
                        cnt     <= cnt + CNT_W'(1);
                        if (cnt == len - CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.clear_i) begin
                        state   <= IDLE;
                        ready_r <= 1'b1;
                    end else if (bus.data_valid_i) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == len - CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    if (!bus.clear_i) begin
                        done_r  <= 1'b1;
                        error_r <= err_flag;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready_r;
    assign bus.done_o   = done_r;
    assign bus.valid_o  = valid_r;
    assign bus.data_o   = ram_rdata;
    assign bus.reqdev_o = reqdev_r;
    assign bus.error_o  = error_r;
    assign state_dbg    = state;
endmodule

// File: tb/tb_comm_mem_slave.sv
// Self-checking bench for comm_mem_slave: directed scenarios plus randomized transactions
// checked against a word-array memory model and latency rules computed per transaction.
module tb_comm_mem_slave;
    import comm_mem_pkg::*;

    localparam int MEM_WORDS   = 1024;
    localparam int BLOCK_WORDS = 4;
    localparam int ADDR_W      = 27;

    logic   clk;
    logic   rst;
    state_t state_dbg;

    comm_mem_slave_if #(.ADDR_W(ADDR_W)) bus ();

    comm_mem_slave #(
        .MEM_WORDS   (MEM_WORDS),
        .BLOCK_WORDS (BLOCK_WORDS),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clock_i   (clk),
        .reset_i   (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] exp_q[$];
    logic [31:0] wr_data_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.req_i        = 1'b0;
        bus.req_block_i  = 1'b0;
        bus.rw_i         = RW_READ;
        bus.add_i        = '0;
        bus.reqdev_i     = '0;
        bus.data_i       = '0;
        bus.data_valid_i = 1'b0;
        bus.clear_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready",  {31'd0, bus.ready_o}, 32'd1);
        check("rst_done",   {31'd0, bus.done_o},  32'd0);
        check("rst_valid",  {31'd0, bus.valid_o}, 32'd0);
        check("rst_error",  {31'd0, bus.error_o}, 32'd0);
        check("rst_data",   bus.data_o,           32'd0);
        check("rst_reqdev", {29'd0, bus.reqdev_o}, 32'd0);
    endtask

    // One transaction. gap_pct<0 selects the fixed data_valid pattern pat (bit j = drive slot j).
    // clear_at>=0: for reads, the cycle index at which clear_i is raised; for writes, the
    // number of completed writes after which clear_i is raised instead of more data.
    task automatic run_txn(input logic rw, input logic blk, input int word, input int gap_pct,
                           input logic [7:0] pat, input int clear_at, input bit poke);
        int n;
        int base;
        bit oor;
        int writes;
        int done_at;
        int valid_cnt;
        int last_wr;
        int clear_cyc;
        int slot;
        bit dv;
        logic [2:0] dev;
        logic [31:0] e;
        n       = blk ? BLOCK_WORDS : 1;
        base    = blk ? (word / BLOCK_WORDS) * BLOCK_WORDS : word;
        oor     = (base + n > MEM_WORDS);
        dev     = 3'($urandom_range(0, 7));
        writes  = 0;
        done_at = -1;
        valid_cnt = 0;
        last_wr = -1;
        clear_cyc = -1;
        slot    = 0;
        for (int k = 0; k < 20 && bus.ready_o !== 1'b1; k++) @(negedge clk);
        check("ready_before_req", {31'd0, bus.ready_o}, 32'd1);
        bus.req_i       = 1'b1;
        bus.rw_i        = rw;
        bus.req_block_i = blk;
        bus.add_i       = {word[ADDR_W-3:0], 2'($urandom_range(0, 3))};
        bus.reqdev_i    = dev;
        if (!oor && rw == RW_READ) begin
            for (int j = 0; j < n; j++) exp_q.push_back(model_mem[base + j]);
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            idle_inputs();
            if (bus.valid_o) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", bus.data_o, e);
                    check("rd_slot", {31'd0, (i >= 2 && i <= n + 1 && (clear_cyc < 0 || i <= clear_cyc))}, 32'd1);
                end
            end
            if (bus.done_o) begin
                done_at = i;
                check("error_at_done", {31'd0, bus.error_o}, {31'd0, oor});
            end else if (bus.error_o) begin
                check("stray_error", 32'd1, 32'd0);
            end
            check("reqdev_hold", {29'd0, bus.reqdev_o}, {29'd0, dev});
            if (clear_cyc >= 0 && i == clear_cyc + 1) begin
                check("ready_after_clear", {31'd0, bus.ready_o}, 32'd1);
            end
            if (done_at >= 0 || (clear_cyc >= 0 && i >= clear_cyc + 3)) break;
            if (poke && i == 2) begin
                bus.req_i       = 1'b1;
                bus.rw_i        = ~rw;
                bus.req_block_i = ~blk;
                bus.reqdev_i    = ~dev;
                bus.add_i       = 27'h40;
            end
            if (clear_cyc < 0) begin
                if (rw == RW_READ && i == clear_at) begin
                    bus.clear_i = 1'b1;
                    clear_cyc   = i;
                end else if (rw == RW_WRITE && !oor && clear_at >= 0 && writes == clear_at) begin
                    bus.clear_i = 1'b1;
                    clear_cyc   = i;
                end else if (rw == RW_WRITE && !oor && writes < n) begin
                    dv = (gap_pct < 0) ? ((slot < 8) ? pat[slot] : 1'b1)
                                       : ($urandom_range(0, 99) >= gap_pct);
                    slot++;
                    if (dv) begin
                        bus.data_valid_i = 1'b1;
                        bus.data_i = (wr_data_q.size() > 0) ? wr_data_q.pop_front() : $urandom;
                        model_mem[base + writes] = bus.data_i;
                        writes++;
                        last_wr = i;
                    end
                end
            end
        end
        idle_inputs();
        if (clear_cyc >= 0) begin
            check("clear_no_done", done_at, -1);
            exp_q.delete();
        end else begin
            if (oor)                 check("done_cycle", done_at, 2);
            else if (rw == RW_READ)  check("done_cycle", done_at, n + 2);
            else                     check("done_cycle", done_at, last_wr + 2);
            check("valid_count", valid_cnt, (oor || rw == RW_WRITE) ? 0 : n);
            @(negedge clk);
            check("done_one_pulse", {31'd0, bus.done_o}, 32'd0);
            check("ready_after_done", {31'd0, bus.ready_o}, 32'd1);
            if (poke) begin
                @(negedge clk);
                check("poke_not_queued", {31'd0, bus.ready_o}, 32'd1);
                check("poke_reqdev", {29'd0, bus.reqdev_o}, {29'd0, dev});
            end
        end
    endtask

    task automatic reset_mid_read();
        bit saw_done;
        saw_done = 1'b0;
        for (int k = 0; k < 20 && bus.ready_o !== 1'b1; k++) @(negedge clk);
        bus.req_i       = 1'b1;
        bus.rw_i        = RW_READ;
        bus.req_block_i = 1'b1;
        bus.add_i       = 27'h0;
        bus.reqdev_i    = 3'd5;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rstmid_ready", {31'd0, bus.ready_o}, 32'd1);
        check("rstmid_data",  bus.data_o, 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (bus.done_o || bus.valid_o) saw_done = 1'b1;
            @(negedge clk);
        end
        check("rstmid_no_done", {31'd0, saw_done}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int w;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Preload the low window and the top block pair so every later read is known.
        for (int b = 0; b < 16; b++) run_txn(RW_WRITE, 1'b1, b * 4, 0, 8'h0, -1, 1'b0);
        run_txn(RW_WRITE, 1'b1, MEM_WORDS - 8, 0, 8'h0, -1, 1'b0);
        run_txn(RW_WRITE, 1'b1, MEM_WORDS - 4, 0, 8'h0, -1, 1'b0);

        wr_data_q.push_back(32'hDEADBEEF);
        run_txn(RW_WRITE, 1'b0, 32'h10 / WORD_BYTES, 0, 8'h0, -1, 1'b0);
        run_txn(RW_READ,  1'b0, 32'h10 / WORD_BYTES, 0, 8'h0, -1, 1'b0);

        for (int v = 1; v <= 4; v++) wr_data_q.push_back(32'(v));
        run_txn(RW_WRITE, 1'b1, 32'h2C / WORD_BYTES, -1, 8'b0010_1101, -1, 1'b0);
        run_txn(RW_READ,  1'b1, 32'h20 / WORD_BYTES, 0, 8'h0, -1, 1'b0);

        run_txn(RW_READ, 1'b0, MEM_WORDS, 0, 8'h0, -1, 1'b0);
        run_txn(RW_READ, 1'b1, MEM_WORDS - 4, 0, 8'h0, -1, 1'b0);

        run_txn(RW_READ, 1'b1, 8, 0, 8'h0, -1, 1'b1);

        run_txn(RW_WRITE, 1'b1, 16, 0, 8'h0, 2, 1'b0);
        run_txn(RW_READ,  1'b1, 16, 0, 8'h0, -1, 1'b0);

        reset_mid_read();

        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      w = $urandom_range(0, 63);
            else if (r <= 8) w = MEM_WORDS - 8 + $urandom_range(0, 7);
            else             w = MEM_WORDS + $urandom_range(0, 200);
            if ($urandom_range(0, 9) == 0)
                run_txn(RW_READ, 1'b1, w & 63, 30, 8'h0, $urandom_range(1, 5), 1'b0);
            else
                run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, 30, 8'h0, -1, 1'b0);
        end

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
